grant_demux: RTL

Registered 1-to-n demultiplexer on the far side of the priority request/grant mux. It accepts one width-bit word per cycle over a valid/ready handshake and steers it, under a one-hot grant vector, into one of n one-entry output holding registers. Each output drains through its own valid/ready handshake. An invalid grant (zero or multi-hot) falls back to a default channel and is counted.

---
 rtl/grant_demux_pkg.sv | 31 +++
 rtl/grant_demux_chan_reg.sv | 31 +++
 rtl/grant_demux.sv | 72 +++++++
 3 files changed

// File: rtl/grant_demux_pkg.sv
// rtl/grant_demux_pkg.sv - shared constants and grant decode helpers for grant_demux
// Contents: MAX_N / IDX_W size the grant decode for up to 16 channels,
//           ERR_CNT_W is the invalid-grant counter width,
//           onehot_ok() detects zero/multi-hot grants, onehot_idx() encodes one-hot to index.
package grant_demux_pkg;

  localparam int MAX_N     = 16;
  localparam int IDX_W     = 4;
  localparam int ERR_CNT_W = 8;

  // True only when exactly one bit is set; zero and multi-hot both fail.
  function automatic logic onehot_ok(input logic [MAX_N-1:0] g);
    int cnt;
    cnt = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (g[i]) cnt++;
    end
    return (cnt == 1);
  endfunction

  // Index of the set bit; only meaningful when onehot_ok(g) holds.
  function automatic logic [IDX_W-1:0] onehot_idx(input logic [MAX_N-1:0] g);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (g[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/grant_demux_chan_reg.sv
// rtl/grant_demux_chan_reg.sv - one-entry output holding register with full flag
// Ports: clk, rst_n (async active-low); load/d write a word; drain consumes it;
//        full marks a held word; q holds the last word loaded (kept after drain).
module demux_chan_reg #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             drain,
  input  logic [width-1:0] d,
  output logic             full,
  output logic [width-1:0] q
);

  // A load in the same cycle as a drain wins: the slot refills and stays full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      q    <= '0;
    end else begin
      if (load) begin
        full <= 1'b1;
        q    <= d;
      end else if (drain) begin
        full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/grant_demux.sv
// rtl/grant_demux.sv - registered 1-to-n grant-steered demultiplexer
// Ports: clk, rst_n (async active-low); in_data/in_valid/in_ready input handshake;
//        grant one-hot target; out_data (channel i at [i*width +: width]), out_valid,
//        out_ready per-channel drain; sel_err pulse and err_cnt count for invalid grants.
module grant_demux
  import grant_demux_pkg::*;
#(
  parameter int width   = 4,
  parameter int n       = 4,
  parameter int def_sel = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [width-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [n-1:0]         grant,
  output logic [n*width-1:0]   out_data,
  output logic [n-1:0]         out_valid,
  input  logic [n-1:0]         out_ready,
  output logic                 sel_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  logic [MAX_N-1:0] grant_ext;
  logic             inv;
  logic [IDX_W-1:0] tgt;
  logic [n-1:0]     sel;
  logic [n-1:0]     full;
  logic [n-1:0]     load;
  logic             accept;

  assign grant_ext = MAX_N'(grant);

  always_comb begin
    inv = !onehot_ok(grant_ext);
    tgt = inv ? IDX_W'(def_sel) : onehot_idx(grant_ext);
  end

  // Ready if the target slot is empty or drains this cycle (pass-through refill).
  assign in_ready  = |(sel & (~full | out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = full;

  for (genvar i = 0; i < n; i++) begin : g_chan
    assign sel[i]  = (tgt == IDX_W'(i));
    assign load[i] = accept && sel[i];

    demux_chan_reg #(.width(width)) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[i]),
      .drain (out_ready[i]),
      .d     (in_data),
      .full  (full[i]),
      .q     (out_data[i*width +: width])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      sel_err <= accept && inv;
      if (accept && inv && (err_cnt != {ERR_CNT_W{1'b1}})) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule
